fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencing controller for the instruction-fetch stage of the 5-stage MIPS pipeline. Loads a program into the instruction memory through a word-wide loader port, then flushes the pipeline and releases the PC. While running it drives the PC freeze and IF/ID freeze/flush from hazard, branch and halt requests. It sits between the loader/debug interface, the hazard unit and the IF stage, and owns every control input of the PC register and the IF/ID register.

## Interface
Parameters:
- ADDR_W, 10, instruction-memory word-address width (1024 words)
- FLUSH_CYCLES, 5, pipeline-drain cycles between load completion and run
- MAX_STALL, 15, consecutive hazard cycles that trigger a stall timeout

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- load_valid  in  1  loader word present
- load_data  in  32  loader instruction word
- load_done  in  1  last word / end of program
- load_ready  out  1  controller accepts loader words
- imem_we  out  1  instruction-memory write strobe
- imem_waddr  out  ADDR_W  word write address
- imem_wdata  out  32  write data
- hazard  in  1  load-use stall request from hazard unit
- branch_taken  in  1  branch resolved taken this cycle
- halt_req  in  1  debug halt request
- resume  in  1  leave HALT
- pc_freeze  out  1  hold PC register
- pc_clear  out  1  force PC to 0
- ifid_freeze  out  1  hold IF/ID register
- ifid_flush  out  1  clear IF/ID to NOP (all-zero word)
- core_run  out  1  high in RUN
- load_ovf  out  1  sticky: load wrapped past top address
- stall_err  out  1  sticky: stall timeout occurred

## Operation
- States: IDLE, LOAD, FLUSH, RUN, HALT. Reset -> IDLE.
- Reset values: all outputs 0 except pc_freeze=1, ifid_flush=1, load_ready=1; write pointer 0, counters 0, stickies 0.
- IDLE: load_ready=1, pc_freeze=1, ifid_flush=1. Accepted word (load_valid & load_ready) -> LOAD.
- LOAD: load_ready=1. Each accepted word is written at the write pointer, and the pointer increments. The pointer wraps from 2^ADDR_W-1 to 0 and sets load_ovf. load_done is sampled only together with an accepted word: that word is written, then the FSM goes to FLUSH.
- FLUSH: pc_clear=1, pc_freeze=1, ifid_flush=1, load_ready=0, for exactly FLUSH_CYCLES cycles (down-counter), then RUN.
- RUN: core_run=1, load_ready=0. Combinational priority, highest first:
  - halt_req: pc_freeze=1, ifid_freeze=1, go to HALT.
  - branch_taken: ifid_flush=1, pc_freeze=0 (PC takes the branch target), stall counter cleared.
  - hazard: pc_freeze=1, ifid_freeze=1, stall counter +1. When the counter reaches MAX_STALL, stall_err is set and the FSM goes to HALT.
  - None of the above: all freezes 0, stall counter cleared.
- HALT: pc_freeze=1, ifid_freeze=1, core_run=0, load_ready=1.
  - resume -> RUN, stall counter cleared.
  - An accepted loader word restarts the load: the pointer resets to 0, that word is written at address 0, the FSM goes to LOAD, and load_ovf is cleared.
  - resume and load_valid together: the load wins.
- Stickies clear only on reset or on a new load from HALT.

## Timing
- Loader writes are registered. A word accepted in cycle N appears on imem_we/imem_waddr/imem_wdata in cycle N+1 for exactly one cycle. Back-to-back words are accepted every cycle.
- RUN freeze/flush outputs are combinational from hazard/branch_taken/halt_req in the same cycle. State changes take effect on the next edge.
- The first fetch from address 0 happens on the first RUN cycle. Latency from the load_done word to core_run = 1 + FLUSH_CYCLES cycles.
- Stall timeout: the HALT entry edge is the edge on which the MAX_STALL-th consecutive hazard cycle is registered.
- Reset asserted mid-operation immediately forces reset values; an imem_we pulse in flight is dropped.

## Test plan
- Load 3 words (0x20010A0A, 0x04011000, 0x0C011800), load_done on the third -> imem_we pulses at addresses 0,1,2 one cycle after each word; pc_clear high for exactly 5 cycles; core_run rises 6 cycles after the last word.
- In RUN: hazard for 2 cycles -> pc_freeze=ifid_freeze=1 for those 2 cycles only, stall_err=0.
- In RUN: hazard and branch_taken in the same cycle -> ifid_flush=1, pc_freeze=0, ifid_freeze=0.
- In RUN: hazard held for 15 cycles -> stall_err=1, HALT entered, core_run=0; resume -> RUN with stall_err still 1.
- Load 1025 words with ADDR_W=10 -> the 1025th word is written at address 0 and load_ovf=1.
- In HALT: load_valid and resume in the same cycle -> LOAD entered, the word is written at address 0, load_ovf cleared. Drop rst mid-LOAD -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencing controller.
// Loads a program into instruction memory, drains the pipeline, then runs
// the PC / IF-ID register controls from hazard, branch and halt requests.
module fetch_ctrl #(
   parameter int ADDR_W       = 10,
   parameter int FLUSH_CYCLES = 5,
   parameter int MAX_STALL    = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   input  logic [31:0]       load_data,
   input  logic              load_done,
   output logic              load_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   input  logic              hazard,
   input  logic              branch_taken,
   input  logic              halt_req,
   input  logic              resume,
   output logic              pc_freeze,
   output logic              pc_clear,
   output logic              ifid_freeze,
   output logic              ifid_flush,
   output logic              core_run,
   output logic              load_ovf,
   output logic              stall_err
);

   localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
   localparam int SC_W = $clog2(MAX_STALL + 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_FLUSH = 3'd2,
      ST_RUN   = 3'd3,
      ST_HALT  = 3'd4
   } state_t;

   state_t             state_r;
   logic [ADDR_W-1:0]  wptr_r;
   logic [FC_W-1:0]    flush_cnt_r;
   logic [SC_W-1:0]    stall_cnt_r;
   logic               imem_we_r;
   logic [ADDR_W-1:0]  imem_waddr_r;
   logic [31:0]        imem_wdata_r;
   logic               load_ovf_r;
   logic               stall_err_r;

   logic               load_ready_s;
   logic               pc_freeze_s;
   logic               pc_clear_s;
   logic               ifid_freeze_s;
   logic               ifid_flush_s;
   logic               core_run_s;
   logic               accept_s;

   assign accept_s = load_valid & load_ready_s;

   // Control decode: state-based, plus same-cycle RUN priority on requests.
   always_comb begin
      load_ready_s  = 1'b0;
      pc_freeze_s   = 1'b0;
      pc_clear_s    = 1'b0;
      ifid_freeze_s = 1'b0;
      ifid_flush_s  = 1'b0;
      core_run_s    = 1'b0;
      case (state_r)
         ST_IDLE, ST_LOAD: begin
            load_ready_s = 1'b1;
            pc_freeze_s  = 1'b1;
            ifid_flush_s = 1'b1;
         end
         ST_FLUSH: begin
            pc_clear_s   = 1'b1;
            pc_freeze_s  = 1'b1;
            ifid_flush_s = 1'b1;
         end
         ST_RUN: begin
            core_run_s = 1'b1;
            if (halt_req) begin
               pc_freeze_s   = 1'b1;
               ifid_freeze_s = 1'b1;
            end else if (branch_taken) begin
               ifid_flush_s = 1'b1;
            end else if (hazard) begin
               pc_freeze_s   = 1'b1;
               ifid_freeze_s = 1'b1;
            end else begin
               pc_freeze_s   = 1'b0;
               ifid_freeze_s = 1'b0;
            end
         end
         ST_HALT: begin
            load_ready_s  = 1'b1;
            pc_freeze_s   = 1'b1;
            ifid_freeze_s = 1'b1;
         end
         default: begin
            load_ready_s = 1'b1;
            pc_freeze_s  = 1'b1;
            ifid_flush_s = 1'b1;
         end
      endcase
   end

   // Sequencer: state, write pointer, drain/stall counters, loader write port, stickies.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         wptr_r       <= '0;
         flush_cnt_r  <= '0;
         stall_cnt_r  <= '0;
         imem_we_r    <= 1'b0;
         imem_waddr_r <= '0;
         imem_wdata_r <= 32'h0000_0000;
         load_ovf_r   <= 1'b0;
         stall_err_r  <= 1'b0;
      end else begin
         imem_we_r <= 1'b0;
         case (state_r)
            ST_IDLE, ST_LOAD: begin
               if (accept_s) begin
                  imem_we_r    <= 1'b1;
                  imem_waddr_r <= wptr_r;
                  imem_wdata_r <= load_data;
                  wptr_r       <= wptr_r + ADDR_W'(1);
                  if (wptr_r == {ADDR_W{1'b1}}) begin
                     load_ovf_r <= 1'b1;
                  end
                  if (load_done) begin
                     state_r     <= ST_FLUSH;
                     flush_cnt_r <= FC_W'(FLUSH_CYCLES - 1);
                  end else begin
                     state_r <= ST_LOAD;
                  end
               end
            end
            ST_FLUSH: begin
               if (flush_cnt_r == FC_W'(0)) begin
                  state_r     <= ST_RUN;
                  stall_cnt_r <= '0;
               end else begin
                  flush_cnt_r <= flush_cnt_r - FC_W'(1);
               end
            end
            ST_RUN: begin
               if (halt_req) begin
                  state_r <= ST_HALT;
               end else if (branch_taken) begin
                  stall_cnt_r <= '0;
               end else if (hazard) begin
                  // The MAX_STALL-th consecutive hazard cycle is the one that trips the timeout.
                  if (stall_cnt_r == SC_W'(MAX_STALL - 1)) begin
                     stall_err_r <= 1'b1;
                     state_r     <= ST_HALT;
                  end
                  stall_cnt_r <= stall_cnt_r + SC_W'(1);
               end else begin
                  stall_cnt_r <= '0;
               end
            end
            ST_HALT: begin
               // A loader word outranks resume and restarts the program from address 0.
               if (accept_s) begin
                  imem_we_r    <= 1'b1;
                  imem_waddr_r <= '0;
                  imem_wdata_r <= load_data;
                  wptr_r       <= ADDR_W'(1);
                  load_ovf_r   <= 1'b0;
                  stall_err_r  <= 1'b0;
                  stall_cnt_r  <= '0;
                  if (load_done) begin
                     state_r     <= ST_FLUSH;
                     flush_cnt_r <= FC_W'(FLUSH_CYCLES - 1);
                  end else begin
                     state_r <= ST_LOAD;
                  end
               end else if (resume) begin
                  state_r     <= ST_RUN;
                  stall_cnt_r <= '0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign load_ready  = load_ready_s;
   assign pc_freeze   = pc_freeze_s;
   assign pc_clear    = pc_clear_s;
   assign ifid_freeze = ifid_freeze_s;
   assign ifid_flush  = ifid_flush_s;
   assign core_run    = core_run_s;
   assign imem_we     = imem_we_r;
   assign imem_waddr  = imem_waddr_r;
   assign imem_wdata  = imem_wdata_r;
   assign load_ovf    = load_ovf_r;
   assign stall_err   = stall_err_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        load_valid;
   logic [31:0] load_data;
   logic        load_done;
   logic        load_ready;
   logic        imem_we;
   logic [9:0]  imem_waddr;
   logic [31:0] imem_wdata;
   logic        hazard;
   logic        branch_taken;
   logic        halt_req;
   logic        resume;
   logic        pc_freeze;
   logic        pc_clear;
   logic        ifid_freeze;
   logic        ifid_flush;
   logic        core_run;
   logic        load_ovf;
   logic        stall_err;

   int n_tests;
   int n_fail;

   // {load_ready, imem_we, pc_freeze, pc_clear, ifid_freeze, ifid_flush, core_run, load_ovf, stall_err}
   logic [8:0] outs;
   assign outs = {load_ready, imem_we, pc_freeze, pc_clear, ifid_freeze,
                  ifid_flush, core_run, load_ovf, stall_err};

   localparam logic [8:0] RESET_V = 9'b1_0_1_0_0_1_0_0_0;

   fetch_ctrl #(.ADDR_W(10), .FLUSH_CYCLES(5), .MAX_STALL(15)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_data(load_data), .load_done(load_done),
      .load_ready(load_ready),
      .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .hazard(hazard), .branch_taken(branch_taken), .halt_req(halt_req),
      .resume(resume),
      .pc_freeze(pc_freeze), .pc_clear(pc_clear), .ifid_freeze(ifid_freeze),
      .ifid_flush(ifid_flush), .core_run(core_run),
      .load_ovf(load_ovf), .stall_err(stall_err)
   );

   // 100 MHz free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] prog [3];
   int          k;
   int          clr_cnt;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      prog[0] = 32'h2001_0A0A;
      prog[1] = 32'h0401_1000;
      prog[2] = 32'h0C01_1800;
      rst = 1'b0; load_valid = 1'b0; load_data = 32'h0; load_done = 1'b0;
      hazard = 1'b0; branch_taken = 1'b0; halt_req = 1'b0; resume = 1'b0;

      #12;
      check_eq("reset_outs", outs, RESET_V);
      #5 rst = 1'b1;
      step();
      check_eq("idle_outs", outs, RESET_V);

      // Three-word program, load_done on the last word.
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1;
         load_data  = prog[i];
         load_done  = (i == 2);
         step();
         check_eq("load_we_addr", {imem_we, imem_waddr}, {1'b1, 10'(i)});
         check_eq("load_wdata", imem_wdata, prog[i]);
      end
      load_valid = 1'b0; load_done = 1'b0;
      check_eq("flush_first_outs", outs, 9'b0_1_1_1_0_1_0_0_0);

      k = 0; clr_cnt = 0;
      while (!core_run && k < 20) begin
         if (pc_clear) clr_cnt++;
         step();
         k++;
      end
      check_eq("pc_clear_cycles", clr_cnt, 5);
      check_eq("run_latency", k + 1, 6);
      check_eq("run_outs", outs, 9'b0_0_0_0_0_0_1_0_0);

      // Two-cycle hazard.
      hazard = 1'b1; #1;
      check_eq("haz1_freeze", {pc_freeze, ifid_freeze}, 2'b11);
      step();
      check_eq("haz2_freeze", {pc_freeze, ifid_freeze}, 2'b11);
      hazard = 1'b0; #1;
      check_eq("haz_release", {pc_freeze, ifid_freeze, stall_err, core_run}, 4'b0001);

      // Branch outranks hazard.
      hazard = 1'b1; branch_taken = 1'b1; #1;
      check_eq("branch_over_haz", {ifid_flush, pc_freeze, ifid_freeze}, 3'b100);
      step();
      hazard = 1'b0; branch_taken = 1'b0;
      step();

      // Stall timeout after 15 consecutive hazard cycles.
      hazard = 1'b1;
      repeat (14) step();
      check_eq("stall_14_still_run", {core_run, stall_err}, 2'b10);
      step();
      hazard = 1'b0;
      check_eq("stall_halt_outs", outs, 9'b1_0_1_0_1_0_0_0_1);
      resume = 1'b1;
      step();
      resume = 1'b0;
      check_eq("resume_run_err", {core_run, stall_err}, 2'b11);

      // Halt outranks branch and hazard.
      halt_req = 1'b1; branch_taken = 1'b1; hazard = 1'b1; #1;
      check_eq("halt_prio", {pc_freeze, ifid_freeze, ifid_flush}, 3'b110);
      step();
      halt_req = 1'b0; branch_taken = 1'b0; hazard = 1'b0;
      check_eq("halt_outs", outs, 9'b1_0_1_0_1_0_0_0_1);

      // 1025-word load from HALT: wraps onto address 0.
      for (int i = 0; i < 1025; i++) begin
         load_valid = 1'b1;
         load_data  = 32'hC0DE_0000 | 32'(i);
         load_done  = (i == 1024);
         step();
         check_eq("big_we_addr", {imem_we, imem_waddr}, {1'b1, 10'(i % 1024)});
         if (i == 0) check_eq("big_err_cleared", stall_err, 1'b0);
         if (i == 1022) check_eq("big_no_ovf_yet", load_ovf, 1'b0);
      end
      load_valid = 1'b0; load_done = 1'b0;
      check_eq("big_wrap_data", imem_wdata, 32'hC0DE_0400);
      check_eq("big_ovf", load_ovf, 1'b1);
      k = 0;
      while (!core_run && k < 20) begin
         step();
         k++;
      end
      check_eq("big_run_reached", core_run, 1'b1);
      check_eq("ovf_sticky_run", load_ovf, 1'b1);

      // HALT, then load_valid together with resume: load wins.
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      load_valid = 1'b1; resume = 1'b1; load_data = 32'h1234_5678;
      step();
      resume = 1'b0;
      check_eq("reload_we_addr", {imem_we, imem_waddr}, {1'b1, 10'd0});
      check_eq("reload_wdata", imem_wdata, 32'h1234_5678);
      check_eq("reload_state", {load_ovf, core_run, load_ready}, 3'b001);
      load_data = 32'h8765_4321;
      step();
      check_eq("reload_next_addr", {imem_we, imem_waddr}, {1'b1, 10'd1});

      // Asynchronous reset mid-LOAD with a write pulse in flight.
      load_data = 32'hDEAD_BEEF;
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check_eq("midload_reset", outs, RESET_V);
      check_eq("midload_waddr", imem_waddr, 10'd0);
      load_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
